// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam logic [INSTR_W-1:0] PC_STEP = 32'd4;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  // IF/ID pipeline register contents
  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_plus8;
    logic               valid;
  } ifid_t;

  // Word-align a redirect address; the low two bits are ignored.
  function automatic logic [INSTR_W-1:0] align_word(input logic [INSTR_W-1:0] addr);
    return {addr[INSTR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: hazard/redirect controls, instruction-memory port and IF/ID outputs.
interface fetch_stage_if;
  import fetch_pkg::*;

  logic               Stall;
  logic               Flush;
  logic               BranchTaken;
  logic [INSTR_W-1:0] BranchTarget;
  logic [INSTR_W-1:0] PC;
  logic [INSTR_W-1:0] Instr;
  logic [INSTR_W-1:0] InstrD;
  logic [INSTR_W-1:0] PCPlus8D;
  logic               ValidD;
  logic               FetchOOR;
  logic               Halted;

  // Environment side: pipeline control and instruction memory
  modport master (
    output Stall, Flush, BranchTaken, BranchTarget, Instr,
    input  PC, InstrD, PCPlus8D, ValidD, FetchOOR, Halted
  );

  // Fetch stage side
  modport slave (
    input  Stall, Flush, BranchTaken, BranchTarget, Instr,
    output PC, InstrD, PCPlus8D, ValidD, FetchOOR, Halted
  );

endinterface

// File: rtl/fetch_ifid_reg.sv
// IF/ID pipeline register with load, hold and bubble controls.
// bubble has priority over load; neither asserted holds the contents.
module fetch_ifid_reg
  import fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  logic  bubble,
  input  ifid_t d,
  output ifid_t q
);

  // Register update: bubble clears only the valid bit, load captures a new entry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (bubble) begin
      q.valid <= 1'b0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT sequencer and IF/ID register.
// Optional halt-on-zero-word detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [INSTR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned        IMEM_WORDS = 128
) (
  input  logic          CLK,
  input  logic          RESETn,
  fetch_stage_if.slave  fif
);

  localparam logic [INSTR_W:0] OOR_LIMIT = 33'(IMEM_WORDS) << 2;

  fetch_state_t       state_q, state_d;
  logic [INSTR_W-1:0] pc_q, pc_d;
  logic               ifid_load;
  logic               ifid_bubble;
  ifid_t              ifid_d;
  ifid_t              ifid_q;
  logic               halt_word;

`ifdef FETCH_HALT_DETECT_EN
  assign halt_word  = (fif.Instr == '0);
  assign fif.Halted = (state_q == HALT);
`else
  assign halt_word  = 1'b0;
  assign fif.Halted = 1'b0;
`endif

  // State and PC registers
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  // Next state, next PC and IF/ID controls; redirect beats stall beats advance
  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    ifid_load       = 1'b0;
    ifid_bubble     = 1'b0;
    ifid_d.instr    = fif.Instr;
    ifid_d.pc_plus8 = pc_q + (PC_STEP << 1);
    ifid_d.valid    = ~fif.Flush;
    unique case (state_q)
      BOOT: begin
        state_d     = RUN;
        ifid_bubble = 1'b1;
      end
      RUN: begin
        if (fif.BranchTaken) begin
          pc_d        = align_word(fif.BranchTarget);
          ifid_bubble = 1'b1;
        end else if (fif.Stall) begin
          // Flush during a stall kills the held entry without reloading it
          ifid_bubble = fif.Flush;
        end else if (halt_word) begin
          state_d     = HALT;
          ifid_bubble = 1'b1;
        end else begin
          pc_d      = pc_q + PC_STEP;
          ifid_load = 1'b1;
        end
      end
      HALT: begin
        ifid_bubble = 1'b1;
        if (fif.BranchTaken) begin
          state_d = RUN;
          pc_d    = align_word(fif.BranchTarget);
        end
      end
      default: begin
        state_d     = BOOT;
        ifid_bubble = 1'b1;
      end
    endcase
  end

  fetch_ifid_reg u_ifid (
    .clk    (CLK),
    .rst_n  (RESETn),
    .load   (ifid_load),
    .bubble (ifid_bubble),
    .d      (ifid_d),
    .q      (ifid_q)
  );

  assign fif.PC       = pc_q;
  assign fif.InstrD   = ifid_q.instr;
  assign fif.PCPlus8D = ifid_q.pc_plus8;
  assign fif.ValidD   = ifid_q.valid;
  assign fif.FetchOOR = ({1'b0, pc_q} >= OOR_LIMIT);

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage with a behavioural fetch model and random controls.
module tb_fetch_stage;

  localparam int unsigned IMEM_WORDS = 128;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic CLK = 1'b0;
  logic RESETn;

  fetch_stage_if fif ();

  fetch_stage #(.RESET_PC(RESET_PC), .IMEM_WORDS(IMEM_WORDS)) dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .fif    (fif)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p8;
    logic        valid;
    logic        oor;
    logic        halted;
  } exp_t;

  exp_t        sb[$];
  int          passed = 0;
  int          total  = 0;
  logic [31:0] imem [IMEM_WORDS];

  // Reference model state
  int          mode;
  logic [31:0] mpc, minstr, mp8;
  logic        mvalid;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if ({32'b0, addr} < 64'(IMEM_WORDS) * 4) return imem[addr[31:2]];
    return 32'hDEAD_0000 ^ addr;
  endfunction

  assign fif.Instr = mem_word(fif.PC);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic halt_on_zero();
`ifdef FETCH_HALT_DETECT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    mode = M_BOOT; mpc = RESET_PC; minstr = '0; mp8 = '0; mvalid = 1'b0;
  endtask

  // One clock of fetch behaviour described by its rules
  task automatic model_step(input logic s, input logic f, input logic b, input logic [31:0] t);
    logic [31:0] w;
    if (mode == M_BOOT) begin
      mode = M_RUN; mvalid = 1'b0;
    end else if (mode == M_HALT) begin
      mvalid = 1'b0;
      if (b) begin mpc = t & ~32'd3; mode = M_RUN; end
    end else if (b) begin
      mpc = t & ~32'd3; mvalid = 1'b0;
    end else if (s) begin
      mvalid = mvalid & ~f;
    end else begin
      w = mem_word(mpc);
      if (halt_on_zero() && w == 32'd0) begin
        mode = M_HALT; mvalid = 1'b0;
      end else begin
        minstr = w; mp8 = mpc + 32'd8; mvalid = ~f; mpc = mpc + 32'd4;
      end
    end
  endtask

  task automatic step(input logic s, input logic f, input logic b, input logic [31:0] t);
    exp_t e;
    fif.Stall = s; fif.Flush = f; fif.BranchTaken = b; fif.BranchTarget = t;
    @(posedge CLK);
    model_step(s, f, b, t);
    #1;
    e.pc = mpc; e.instr = minstr; e.p8 = mp8; e.valid = mvalid;
    e.oor = ({32'b0, mpc} >= 64'(IMEM_WORDS) * 4);
    e.halted = (mode == M_HALT);
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  // Assert reset between edges, check outputs immediately, then release between edges
  task automatic reset_check(input string tag);
    @(negedge CLK);
    #2;
    RESETn = 1'b0;
    #1;
    chk({tag, "_pc"},     fif.PC,       RESET_PC);
    chk({tag, "_instr"},  fif.InstrD,   32'h0);
    chk({tag, "_p8"},     fif.PCPlus8D, 32'h0);
    chk({tag, "_valid"},  {31'b0, fif.ValidD}, 32'h0);
    chk({tag, "_halted"}, {31'b0, fif.Halted}, 32'h0);
    model_reset();
    @(negedge CLK);
    #2;
    RESETn = 1'b1;
  endtask

  // Monitor: compare registered outputs against queued expectations on the falling edge
  always @(negedge CLK) begin
    exp_t e;
    if (RESETn === 1'b1 && sb.size() > 0) begin
      e = sb.pop_front();
      chk("pc",     fif.PC, e.pc);
      chk("valid",  {31'b0, fif.ValidD},   {31'b0, e.valid});
      chk("oor",    {31'b0, fif.FetchOOR}, {31'b0, e.oor});
      chk("halted", {31'b0, fif.Halted},   {31'b0, e.halted});
      if (e.valid) begin
        chk("instr", fif.InstrD,   e.instr);
        chk("p8",    fif.PCPlus8D, e.p8);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(IMEM_WORDS); i++) imem[i] = $urandom | 32'h1;
    imem[9] = 32'h0;
    RESETn = 1'b0;
    fif.Stall = 1'b0; fif.Flush = 1'b0; fif.BranchTaken = 1'b0; fif.BranchTarget = '0;
    model_reset();
    #23;
    chk("rst0_pc",    fif.PC, RESET_PC);
    chk("rst0_valid", {31'b0, fif.ValidD}, 32'h0);
    chk("rst0_instr", fif.InstrD, 32'h0);
    @(negedge CLK); #2; RESETn = 1'b1;

    // Boot and straight-line fetch
    idle(5);
    // Stall for three cycles then resume
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(1);
    // Redirect to a misaligned target, alone and under stall+flush
    step(1'b0, 1'b0, 1'b1, 32'h23);
    idle(2);
    step(1'b1, 1'b1, 1'b1, 32'h23);
    idle(2);
    // Flush during stall, then release
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    idle(2);
    // Flush on a normal advance
    step(1'b0, 1'b1, 1'b0, 32'h0);
    idle(1);
    // Zero word at address 36
    step(1'b0, 1'b0, 1'b1, 32'd32);
    idle(3);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    idle(1);
    step(1'b0, 1'b0, 1'b1, 32'h0);
    idle(3);
    // Out-of-range boundary and wraparound
    step(1'b0, 1'b0, 1'b1, 32'd4 * IMEM_WORDS - 32'd8);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE);
    idle(3);

    // Random control traffic
    for (int i = 0; i < 400; i++) begin
      logic s, f, b;
      logic [31:0] t;
      s = ($urandom_range(99) < 25);
      f = ($urandom_range(99) < 15);
      b = ($urandom_range(99) < 10);
      t = ($urandom_range(99) < 10) ? $urandom : 32'($urandom_range(600));
      step(s, f, b, t);
    end

    // Reset mid-stall, with redirect requested across the release edge
    step(1'b0, 1'b0, 1'b1, 32'd16);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0);
    reset_check("rst_stall");
    step(1'b1, 1'b1, 1'b1, 32'd64);
    idle(3);

    // Reset while sitting on the zero word (halted in the detect build)
    step(1'b0, 1'b0, 1'b1, 32'd32);
    idle(4);
    reset_check("rst_halt");
    idle(4);

    repeat (2) @(negedge CLK);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded by reset.
REQ-002 Parameter IMEM_WORDS, default 128, is the instruction-memory depth in words; it is used only for the FetchOOR flag.
REQ-003 Port CLK  input  1  is the single rising-edge clock.
REQ-004 Port RESETn  input  1  is the reset: asynchronous, active-low.
REQ-005 Port Stall  input  1  holds the PC and the IF/ID register.
REQ-006 Port Flush  input  1  kills the IF/ID contents, inserting a bubble.
REQ-007 Port BranchTaken  input  1  redirects fetch to BranchTarget.
REQ-008 Port BranchTarget  input  32  is the redirect address.
REQ-009 Port PC  output  32  is the registered fetch address, driven to instruction memory.
REQ-010 Port Instr  input  32  is the word returned combinationally by instruction memory for PC.
REQ-011 Port InstrD  output  32  is the IF/ID instruction register.
REQ-012 Port PCPlus8D  output  32  is the IF/ID copy of fetch PC+8 (ARM PC-read value).
REQ-013 Port ValidD  output  1  marks InstrD as a real instruction (1) or a bubble (0).
REQ-014 Port FetchOOR  output  1  is high when PC >= IMEM_WORDS*4.
REQ-015 Port Halted  output  1  is the halt indicator; it is present in both builds.

Function
REQ-016 The FSM SHALL have states BOOT, RUN and HALT; HALT is reachable only when FETCH_HALT_DETECT_EN is defined.
REQ-017 BOOT SHALL last exactly one cycle after RESETn deasserts, with PC=RESET_PC and ValidD=0, then go to RUN unconditionally.
REQ-018 In RUN, cycle priority SHALL be: BranchTaken, then Stall, then normal advance.
REQ-019 Normal advance SHALL do PC<=PC+4, InstrD<=Instr, PCPlus8D<=PC+8, and ValidD<=~Flush.
REQ-020 On BranchTaken the block SHALL set PC<={BranchTarget[31:2],2'b00} and ValidD<=0, whatever Stall and Flush are.
REQ-021 On Stall without BranchTaken the block SHALL hold PC, InstrD and PCPlus8D; ValidD<=ValidD&~Flush.
REQ-022 BranchTarget[1:0] SHALL be ignored, so PC[1:0] is always 00.
REQ-023 PC+4 and PC+8 SHALL wrap modulo 2^32 (32'hFFFF_FFFC+4 gives 0), with no flag.
REQ-024 FetchOOR SHALL be combinational from PC; fetch is not blocked by it.
REQ-025 Fetch latency SHALL be one cycle: the word at PC appears on InstrD the edge after PC is presented, unless stalled or redirected.
REQ-026 Halted SHALL be 0 in BOOT and RUN.

Reset
REQ-027 RESETn low SHALL asynchronously force PC=RESET_PC, InstrD=0, PCPlus8D=0, ValidD=0, Halted=0 and state BOOT.
REQ-028 Reset asserted mid-branch, mid-stall or in HALT SHALL discard all pending state, with no partial update on the release edge.

Configuration
REQ-029 With FETCH_HALT_DETECT_EN defined, a normal advance in RUN with Instr==32'h0 SHALL enter HALT, load ValidD<=0 and hold PC at the zero word.
REQ-030 In HALT: Halted=1, PC frozen and ValidD=0; BranchTaken SHALL return the FSM to RUN per REQ-020; Stall and Flush SHALL have no effect.
REQ-031 Without FETCH_HALT_DETECT_EN, all-zero words SHALL be fetched as ordinary instructions and Halted SHALL be tied to 0.

Structure
REQ-032 A shared package fetch_pkg SHALL hold the FSM state encoding (BOOT=2'd0, RUN=2'd1, HALT=2'd2), the constants INSTR_W=32 and PC_STEP=4, and the IF/ID bundle typedef {instr, pc_plus8, valid}.
REQ-033 One sub-module, fetch_ifid_reg, SHALL implement the IF/ID register with load, hold and bubble controls; the PC register and FSM stay in fetch_stage.
REQ-034 Instruction memory SHALL remain external; fetch_stage drives PC and samples Instr only.

Verification
REQ-035 Release reset with RESET_PC=0 and memory words 0..3 = A,B,C,D -> PC 0,0,4,8,12; ValidD 0,0,1,1,1; InstrD A,B,C; PCPlus8D 8,12,16.
REQ-036 PC=8, Stall high for 3 cycles -> PC, InstrD and PCPlus8D unchanged for 3 cycles; advance resumes to PC=12 the cycle after Stall drops.
REQ-037 PC=12, BranchTaken=1, BranchTarget=32'h23 -> next PC=32'h20 and ValidD=0; with Stall also high, same result.
REQ-038 Flush pulsed for 1 cycle with Stall=1 -> ValidD=0, PC held; next unstalled cycle -> ValidD=1.
REQ-039 With FETCH_HALT_DETECT_EN, word 9 = 0 -> PC stops at 36, Halted=1, ValidD=0; BranchTaken to 0 -> Halted=0, PC=0. Without the macro -> PC continues to 40, InstrD=0, ValidD=1.
REQ-040 Assert RESETn low in HALT or mid-stall at a non-edge time -> outputs reach reset values immediately; PC=4*IMEM_WORDS gives FetchOOR=1.
